lte_srcxn_inf: RTL

- Parametrised successor source interface for the downlink datapath: selects per TDM antenna slot between the live IQ stream, a remapped capture bank, a constant, a ramp or a PRBS pattern.
- Gates the result with a frame-relative window that may wrap around, and flags frame-head timing errors.
- Configuration is shadowed and takes effect only at a live frame head.
- Sits between the IQ source and the downstream datapath, replacing fixed-width single-mode source muxing.

---
 rtl/lte_srcxn_inf.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/lte_srcxn_inf.sv
// lte_srcxn_inf: downlink source interface. For each TDM antenna slot it picks
// the live IQ word, a remapped capture-bank word, a constant, a ramp or PRBS15.
// The result is gated by a frame-relative (possibly wrapping) window.
// Configuration is shadowed and switches over only at a live frame head.
// Pipeline: input reg -> source mux -> window gate (3 clocks for every mode).

// One capture lane. It stages TDM slot words and publishes them together, so
// readers never see a half-updated set.
module lte_srcxn_cap_lane #(
  parameter int DW  = 32,
  parameter int TDM = 4,
  parameter int SLW = 2
) (
  input  logic                   clk,
  input  logic                   asy_rst,
  input  logic [SLW-1:0]         wr_slot,
  input  logic [DW-1:0]          din,
  output logic [TDM-1:0][DW-1:0] bank
);
  logic [TDM-1:0][DW-1:0] stage;

  // Stage each slot word; when the last slot lands, commit the full set
  always_ff @(posedge clk) begin
    if (asy_rst) begin
      stage <= '0;
      bank  <= '0;
    end else begin
      stage[wr_slot] <= din;
      if (wr_slot == SLW'(TDM-1))
        for (int s = 0; s < TDM; s++)
          bank[s] <= (wr_slot == SLW'(s)) ? din : stage[s];
    end
  end
endmodule

module lte_srcxn_inf #(
  parameter int DW        = 32,
  parameter int NLANE     = 2,
  parameter int TDM       = 4,
  parameter int SELW      = 4,
  parameter int FRAME_LEN = 4915200,
  parameter int CNTW      = 24
) (
  input  logic                  clk,
  input  logic                  asy_rst,
  input  logic                  i_cap_hd,
  input  logic [NLANE*DW-1:0]   i_cap_iq,
  input  logic                  i_framn_hd,
  input  logic [DW-1:0]         i_datan_iq,
  input  logic [2:0]            i_mode,
  input  logic [TDM*SELW-1:0]   i_sel_cfg,
  input  logic [DW-1:0]         i_const_iq,
  input  logic                  i_win_en,
  input  logic [CNTW-1:0]       i_win_start,
  input  logic [CNTW-1:0]       i_win_end,
  input  logic                  i_cfg_upd,
  input  logic                  i_err_clr,
  output logic [DW-1:0]         o_data_iq,
  output logic                  o_fram_hd,
  output logic                  o_slot0,
  output logic                  o_hd_err
);
  localparam int SLW = $clog2(TDM);
  localparam logic [14:0] LFSR_SEED = 15'h7FFF;

  typedef struct packed {
    logic [2:0]          mode;
    logic [TDM*SELW-1:0] sel;
    logic [DW-1:0]       cval;
    logic                win_en;
    logic [CNTW-1:0]     ws;
    logic [CNTW-1:0]     we;
  } cfg_t;

  function automatic logic [TDM*SELW-1:0] sel_ident();
    logic [TDM*SELW-1:0] r;
    r = '0;
    for (int k = 0; k < TDM; k++) r[k*SELW +: SELW] = SELW'(k);
    return r;
  endfunction

  localparam logic [TDM*SELW-1:0] SEL_ID = sel_ident();
  localparam cfg_t CFG_RST = '{mode: 3'd0, sel: SEL_ID, cval: '0,
                               win_en: 1'b0, ws: '0, we: '0};

  // ---------------- capture bank ----------------
  logic [SLW-1:0]                      cap_slot, cap_cur;
  logic [NLANE-1:0][TDM-1:0][DW-1:0]   bank;

  assign cap_cur = i_cap_hd ? '0 : cap_slot + SLW'(1);

  // Capture slot tracks the slot of the last written capture sample
  always_ff @(posedge clk) begin
    if (asy_rst) cap_slot <= '0;
    else         cap_slot <= cap_cur;
  end

  for (genvar n = 0; n < NLANE; n++) begin : g_lane
    lte_srcxn_cap_lane #(.DW(DW), .TDM(TDM), .SLW(SLW)) u_lane (
      .clk     (clk),
      .asy_rst (asy_rst),
      .wr_slot (cap_cur),
      .din     (i_cap_iq[n*DW +: DW]),
      .bank    (bank[n])
    );
  end

  // ---------------- stage 1: input reg, counters, config ----------------
  cfg_t            act, shd;
  logic            pend, seen_hd;
  logic [DW-1:0]   d1_iq;
  logic [SLW-1:0]  slot_cnt;
  logic [CNTW-1:0] cyc_cnt;
  logic [14:0]     lfsr;
  logic [3:1]      hd_pipe;
  logic [3:2]      s0_pipe;
  logic            last_cyc;

  assign last_cyc = (cyc_cnt == CNTW'(FRAME_LEN-1));

  // Register the live sample and align slot/cycle counters and PRBS to it
  always_ff @(posedge clk) begin
    if (asy_rst) begin
      d1_iq      <= '0;
      hd_pipe[1] <= 1'b0;
      slot_cnt   <= '0;
      cyc_cnt    <= '0;
      lfsr       <= LFSR_SEED;
    end else begin
      d1_iq      <= i_datan_iq;
      hd_pipe[1] <= i_framn_hd;
      if (i_framn_hd) begin
        slot_cnt <= '0;
        cyc_cnt  <= '0;
        lfsr     <= LFSR_SEED;
      end else begin
        slot_cnt <= slot_cnt + SLW'(1);
        cyc_cnt  <= last_cyc ? '0 : cyc_cnt + CNTW'(1);
        lfsr     <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
      end
    end
  end

  // Shadow config: a head consumes the old shadow even if an update lands with it
  always_ff @(posedge clk) begin
    if (asy_rst) begin
      act  <= CFG_RST;
      shd  <= CFG_RST;
      pend <= 1'b0;
    end else begin
      if (i_framn_hd && pend) act <= shd;
      if (i_cfg_upd) begin
        shd  <= '{mode: i_mode, sel: i_sel_cfg, cval: i_const_iq,
                  win_en: i_win_en, ws: i_win_start, we: i_win_end};
        pend <= 1'b1;
      end else if (i_framn_hd) begin
        pend <= 1'b0;
      end
    end
  end

  // Sticky head-timing error; the first head after reset only establishes timing
  always_ff @(posedge clk) begin
    if (asy_rst) begin
      seen_hd  <= 1'b0;
      o_hd_err <= 1'b0;
    end else begin
      if (i_framn_hd) seen_hd <= 1'b1;
      if (i_framn_hd && seen_hd && !last_cyc) o_hd_err <= 1'b1;
      else if (i_err_clr)                     o_hd_err <= 1'b0;
    end
  end

  // ---------------- stage 2: source mux + window decision ----------------
  logic [SELW-1:0] sel_idx;
  logic [DW-1:0]   bank_word, src;
  logic            pass;

  // Pick the source word for the current live slot and decide the window
  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < TDM; k++)
      if (slot_cnt == SLW'(k)) sel_idx = act.sel[k*SELW +: SELW];
    bank_word = '0;
    for (int n = 0; n < NLANE; n++)
      for (int s = 0; s < TDM; s++)
        if (sel_idx == SELW'(n*TDM + s)) bank_word = bank[n][s];
    case (act.mode)
      3'd1:    src = bank_word;
      3'd2:    src = act.cval;
      3'd3:    src = {{(DW-15){1'b0}}, lfsr};
      3'd4:    src = {cyc_cnt[DW/2-1:0], cyc_cnt[DW/2-1:0]};
      default: src = d1_iq;
    endcase
    if (!act.win_en)          pass = 1'b1;
    else if (act.ws <= act.we) pass = (cyc_cnt >= act.ws) && (cyc_cnt <= act.we);
    else                       pass = (cyc_cnt >= act.ws) || (cyc_cnt <= act.we);
  end

  logic [DW-1:0] d2_iq;
  logic          d2_pass;

  // Register mux result, window decision and sideband
  always_ff @(posedge clk) begin
    if (asy_rst) begin
      d2_iq      <= '0;
      d2_pass    <= 1'b0;
      hd_pipe[2] <= 1'b0;
      s0_pipe[2] <= 1'b0;
    end else begin
      d2_iq      <= src;
      d2_pass    <= pass;
      hd_pipe[2] <= hd_pipe[1];
      s0_pipe[2] <= (slot_cnt == '0);
    end
  end

  // ---------------- stage 3: window gate / outputs ----------------
  // Zero the data outside the window; sideband stays aligned with the data
  always_ff @(posedge clk) begin
    if (asy_rst) begin
      o_data_iq  <= '0;
      hd_pipe[3] <= 1'b0;
      s0_pipe[3] <= 1'b0;
    end else begin
      o_data_iq  <= d2_pass ? d2_iq : '0;
      hd_pipe[3] <= hd_pipe[2];
      s0_pipe[3] <= s0_pipe[2];
    end
  end

  assign o_fram_hd = hd_pipe[3];
  assign o_slot0   = s0_pipe[3];
endmodule
